// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle datapath: screen geometry and the
// paddle input FSM state encoding.
package pong_pkg;

    localparam int SCREEN_HEIGHT = 480;
    localparam int PADDLE_HEIGHT = 60;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        BLOCKED = 2'd3
    } paddle_state_e;

    function automatic paddle_state_e state_from_levels(input logic up, input logic dn);
        paddle_state_e st;
        case ({up, dn})
            2'b10:   st = UP;
            2'b01:   st = DOWN;
            2'b11:   st = BLOCKED;
            default: st = IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchroniser followed by a counter that accepts a
// new level only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync0_d = btn_raw;
        sync1_d = sync0_q;
        level_d = level_q;
        cnt_d   = '0;
        // The final differing sample flips the level instead of storing DEBOUNCE_CYCLES.
        if (sync1_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Player buttons to paced paddle step strobes. Define PADDLE_AI_EN to add the
// ball-tracking computer-player mode (ai_mode, ball_y, paddle_y ports).
module paddle_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_DIV        = 200000,
    parameter int PADDLE_HEIGHT   = pong_pkg::PADDLE_HEIGHT,
    parameter int AI_DEADBAND     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
`ifdef PADDLE_AI_EN
    input  logic       ai_mode,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
`endif
    output logic       move_up,
    output logic       move_down
);

    import pong_pkg::*;

    localparam int TW = $clog2(MOVE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_DIV - 1);

    logic          up_db, dn_db;
    paddle_state_e state_q, state_d;
    logic          enter_q, enter_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          move_up_q, move_up_d;
    logic          move_down_q, move_down_d;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .level   (up_db)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_down),
        .level   (dn_db)
    );

`ifdef PADDLE_AI_EN
    localparam logic signed [10:0] HALF_H   = 11'(PADDLE_HEIGHT / 2);
    localparam logic signed [10:0] DEADBAND = 11'(AI_DEADBAND);

    logic               ai_mode_q, ai_mode_d;
    logic               ai_edge;
    logic signed [10:0] target, paddle_s;

    always_comb begin
        ai_mode_d = ai_mode;
        ai_edge   = ai_mode ^ ai_mode_q;
        target    = $signed({1'b0, ball_y}) - HALF_H;
        paddle_s  = $signed({1'b0, paddle_y});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ai_mode_q <= 1'b0;
        else        ai_mode_q <= ai_mode_d;
    end
`else
    logic unused_ai_cfg;
    assign unused_ai_cfg = ^{PADDLE_HEIGHT, AI_DEADBAND};
`endif

    // move_up/move_down are single-cycle strobes with no back-pressure: the
    // paddle stage must act on every cycle in which one of them is high.
    always_comb begin
        state_d     = state_from_levels(up_db, dn_db);
        tick        = (tick_cnt_q == TICK_LAST);
        // enter_q marks the first cycle in a new state, restarting the pacing.
        tick_cnt_d  = (enter_q || tick) ? '0 : tick_cnt_q + 1'b1;
        move_up_d   = (state_q == UP)   && (enter_q || tick);
        move_down_d = (state_q == DOWN) && (enter_q || tick);
`ifdef PADDLE_AI_EN
        if (ai_mode || ai_edge) state_d = IDLE;
        if (ai_edge) tick_cnt_d = '0;
        if (ai_mode && ai_mode_q) begin
            move_up_d   = tick && (paddle_s > target + DEADBAND);
            move_down_d = tick && (paddle_s + DEADBAND < target);
        end
`endif
        enter_d = (state_d != state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enter_q     <= 1'b0;
            tick_cnt_q  <= '0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            enter_q     <= enter_d;
            tick_cnt_q  <= tick_cnt_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
        end
    end

    assign move_up   = move_up_q;
    assign move_down = move_down_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl with DEBOUNCE_CYCLES=4, MOVE_DIV=8;
// define PADDLE_AI_EN to also exercise tracking mode.
module tb_paddle_input_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic move_up, move_down;
`ifdef PADDLE_AI_EN
    logic       ai_mode = 1'b0;
    logic [9:0] ball_y = '0;
    logic [9:0] paddle_y = '0;
`endif

    always #5 clk = ~clk;

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .MOVE_DIV        (DIV),
        .PADDLE_HEIGHT   (60),
        .AI_DEADBAND     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
`ifdef PADDLE_AI_EN
        .ai_mode   (ai_mode),
        .ball_y    (ball_y),
        .paddle_y  (paddle_y),
`endif
        .move_up   (move_up),
        .move_down (move_down)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit model_on = 1'b0;
    logic [1:0] exp_q[$];
    int up_times[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Raw samples per posedge; a level flips once the DEB samples taken
    // 2..DEB+1 edges ago all disagree with it. Pulses: one on the edge after a
    // direction run starts, then every DIV edges while the run lasts.
    bit hu[$], hd[$];
    bit lu, ld;
    int st;      // 0 idle, 1 up, 2 down, 3 both
    int run_s;   // edge at which the current state began

    function automatic bit settle(input bit q[$], input bit lev);
        for (int j = 0; j < DEB; j++) begin
            if (q[q.size() - 3 - j] == lev) return lev;
        end
        return !lev;
    endfunction

    function automatic void model_reset();
        hu.delete();
        hd.delete();
        for (int j = 0; j < DEB + 2; j++) begin
            hu.push_back(1'b0);
            hd.push_back(1'b0);
        end
        lu = 1'b0;
        ld = 1'b0;
        st = 0;
        run_s = -1000;
    endfunction

    function automatic bit pulse_due(input int dir);
        if (st != dir) return 1'b0;
        if (run_s == cyc - 1) return 1'b1;
        return (cyc - 1 > run_s) && ((cyc - run_s - 2) % DIV == DIV - 1);
    endfunction

    function automatic void model_step();
        int nst;
        if (!rst_n) begin
            model_reset();
            exp_q.push_back(2'b00);
            return;
        end
        hu.push_back(btn_up);
        hd.push_back(btn_down);
        while (hu.size() > 32) void'(hu.pop_front());
        while (hd.size() > 32) void'(hd.pop_front());
        exp_q.push_back({pulse_due(1), pulse_due(2)});
        nst = (lu && ld) ? 3 : lu ? 1 : ld ? 2 : 0;
        if (nst != st) begin
            st = nst;
            run_s = cyc;
        end
        lu = settle(hu, lu);
        ld = settle(hd, ld);
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (model_on) model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        if (model_on) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("move_up", int'(move_up), int'(e[1]));
                check("move_down", int'(move_down), int'(e[0]));
                check("not_both", int'(move_up & move_down), 0);
            end
            if (move_up === 1'b1) up_times.push_back(cyc);
        end
    end

    // ---------------- drivers ----------------
    task automatic hold(input bit u, input bit d, input int n);
        @(negedge clk);
        #2;
        btn_up = u;
        btn_down = d;
        repeat (n - 1) @(negedge clk);
    endtask

`ifdef PADDLE_AI_EN
    task automatic count_pulses(input int n, output int nu, output int nd);
        nu = 0;
        nd = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            nu += int'(move_up);
            nd += int'(move_down);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int press_edge;
        int waited;
`ifdef PADDLE_AI_EN
        int nu, nd;
`endif
        model_reset();
        model_on = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // idle after reset
        hold(0, 0, 50);

        // up held: first pulse 7 edges after press is sampled, then every 8
        @(negedge clk);
        #2;
        up_times.delete();
        press_edge = cyc + 1;
        btn_up = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check("up_pulses_seen", int'(up_times.size() >= 2), 1);
        if (up_times.size() >= 2) begin
            check("up_first_latency", up_times[0] - press_edge, 2 + DEB + 1);
            check("up_repeat_period", up_times[1] - up_times[0], DIV);
        end
        hold(0, 0, 20);

        // short glitch on down: no effect
        hold(0, 1, 3);
        hold(0, 0, 20);

        // both held, then down released
        hold(1, 1, 30);
        @(negedge clk);
        #2;
        up_times.delete();
        press_edge = cyc + 1;
        btn_down = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("release_pulses_seen", int'(up_times.size() >= 2), 1);
        if (up_times.size() >= 2) begin
            check("release_first_latency", up_times[0] - press_edge, 2 + DEB + 1);
            check("release_repeat_period", up_times[1] - up_times[0], DIV);
        end
        hold(0, 0, 20);

        // reset during a move_up pulse with up held
        hold(1, 0, 1);
        waited = 0;
        while (move_up !== 1'b1 && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("up_pulse_before_reset", int'(move_up), 1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_up", int'(move_up), 0);
        check("reset_drops_down", int'(move_down), 0);
        @(negedge clk);
        #2;
        up_times.delete();
        press_edge = cyc + 1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_pulse_seen", int'(up_times.size() >= 1), 1);
        if (up_times.size() >= 1)
            check("post_reset_latency", up_times[0] - press_edge, 2 + DEB + 1);
        hold(0, 0, 20);

        // randomized button activity
        repeat (60) hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, 14)));
        hold(0, 0, 20);
        @(negedge clk);
        #2 model_on = 1'b0;

`ifdef PADDLE_AI_EN
        ai_mode = 1'b1;
        ball_y = 10'd300;
        paddle_y = 10'd100;
        repeat (16) @(negedge clk);
        count_pulses(64, nu, nd);
        check("ai_below_down", nd, 8);
        check("ai_below_up", nu, 0);
        paddle_y = 10'd268;
        repeat (16) @(negedge clk);
        count_pulses(64, nu, nd);
        check("ai_dead_down", nd, 0);
        check("ai_dead_up", nu, 0);
        ball_y = 10'd20;
        paddle_y = 10'd200;
        repeat (16) @(negedge clk);
        count_pulses(64, nu, nd);
        check("ai_above_up", nu, 8);
        check("ai_above_down", nd, 0);
        ai_mode = 1'b0;
        repeat (4) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Converts raw, asynchronous player buttons into the `move_up` / `move_down` step requests consumed by the paddle position register. It synchronises and debounces each button and arbitrates conflicting presses. It also paces moves so the paddle steps once per `MOVE_DIV` clocks. Optionally, a compiled-in tracking mode drives the paddle toward the ball for a computer player. It sits between the board pushbuttons and the paddle stage, one instance per player.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable synchronised cycles required before a button level change is accepted (≥1).
- `MOVE_DIV`, 200000: clocks between repeated move pulses while a direction is held (≥2).
- `PADDLE_HEIGHT`, 60: paddle height in pixels; used by tracking mode only.
- `AI_DEADBAND`, 4: tracking-mode tolerance in pixels.
- `clk`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `btn_up`  in  1: raw up button, asynchronous, active-high.
- `btn_down`  in  1: raw down button, asynchronous, active-high.
- `move_up`  out  1: registered one-cycle step-up request.
- `move_down`  out  1: registered one-cycle step-down request.
- `ai_mode`  in  1: tracking-mode select (present only with `PADDLE_AI_EN`).
- `ball_y`  in  10: ball top y (present only with `PADDLE_AI_EN`).
- `paddle_y`  in  10: current paddle top y, fed back from the paddle stage (present only with `PADDLE_AI_EN`).

## Operation
- Per button: 2-flop synchroniser, reset to 0.
- Debounce per button:
  - Counter of width `$clog2(DEBOUNCE_CYCLES+1)` increments while the synchronised value differs from the stable level.
  - The counter clears when the values match.
  - On reaching `DEBOUNCE_CYCLES`, the stable level takes the synchronised value and the counter clears.
- Tick counter:
  - Runs 0..`MOVE_DIV`-1 and wraps.
  - `tick` is asserted when the count equals `MOVE_DIV`-1.
  - The counter is forced to 0 on every FSM state change.
- FSM (state from the debounced levels `up_db`, `dn_db`):
  - IDLE: neither pressed.
  - UP: `up_db` only.
  - DOWN: `dn_db` only.
  - BLOCKED: both pressed.
  - Any state can go to any state in one cycle, according to the current levels.
- Outputs:
  - Entering UP (or DOWN) from any other state: `move_up` (or `move_down`) pulses on the next cycle, giving an immediate first step.
  - While remaining in UP/DOWN: one pulse on the cycle after each `tick`.
  - IDLE and BLOCKED: no pulses.
  - `move_up` and `move_down` are never asserted together.
- Releasing one button of a BLOCKED pair enters UP/DOWN and produces an immediate pulse.
- Boundary clamping is not done here; the paddle stage owns the screen limits.

## Timing
- Reset values:
  - `move_up`=0, `move_down`=0.
  - Synchronisers 0, stable levels 0, debounce counters 0.
  - Tick counter 0, FSM=IDLE.
- Press latency: the first pulse is high on cycle 2+`DEBOUNCE_CYCLES`+1 after the first rising edge that samples the pressed level. This assumes the level is held throughout.
- Release latency: pulses stop no later than 2+`DEBOUNCE_CYCLES`+1 cycles after release.
  - A tick pulse already registered still completes its single cycle.
- Repeat period while held: exactly `MOVE_DIV` cycles between pulses, measured from the immediate first pulse.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no state change.
- Reset asserted mid-pulse: outputs drop asynchronously. After release, a held button is re-debounced from scratch.

## Configuration
- `PADDLE_AI_EN` defined:
  - Adds `ai_mode`, `ball_y` and `paddle_y`.
  - While `ai_mode`=1, the buttons are ignored (their debouncers keep running).
  - On each `tick`, the block computes `target = ball_y - PADDLE_HEIGHT/2` in 11-bit signed arithmetic.
  - `move_down` pulses if `paddle_y + AI_DEADBAND < target`.
  - `move_up` pulses if `paddle_y > target + AI_DEADBAND`.
  - Otherwise no pulse.
  - Tracking mode has no immediate first step.
  - Any `ai_mode` edge forces the FSM to IDLE and clears the tick counter.
- `PADDLE_AI_EN` undefined: ports and logic are absent; button behaviour is identical.

## Structure
- The shared package `pong_pkg` holds:
  - `SCREEN_HEIGHT`.
  - `PADDLE_HEIGHT`.
  - The FSM state enum: IDLE, UP, DOWN, BLOCKED.
- Sub-module `button_debounce` (synchroniser + debounce counter + stable level, parameter `DEBOUNCE_CYCLES`), instantiated once per button.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `MOVE_DIV`=8.
- Reset release with buttons low, 50 cycles: `move_up`=`move_down`=0 throughout.
- `btn_up` held from cycle 10: first `move_up` pulse at cycle 17, then at 25, 33, 41; `move_down` stays 0.
- `btn_down` 3-cycle glitch, then low: no pulses, FSM stays IDLE.
- Both held, then `btn_down` released at cycle 60:
  - No pulses while both are held.
  - Single immediate `move_up` 7 cycles after the release is sampled, then every 8 cycles.
- `rst_n` low for 1 cycle during a held `btn_up`: outputs 0 immediately; the next pulse occurs 7 cycles after reset release.
- With `PADDLE_AI_EN` and `ai_mode`=1:
  - `ball_y`=300, `paddle_y`=100: `move_down` on each tick.
  - `paddle_y`=268: no pulses.
  - `ball_y`=20, `paddle_y`=200: `move_up` on each tick.
